// File: rtl/sme.sv
// sme: string-matching engine.
// Holds one text string (1-32 chars) and searches it for patterns (1-8 chars).
// In a pattern, '.' matches any character. A leading '^' matches the string
// start or one space. A trailing '$' matches the string end or one space.
// The SEARCH state tests one start position per clock cycle.
// Build option SME_EARLY_EXIT_EN: when defined, SEARCH stops at the first hit.
// When it is not defined, SEARCH always scans all 32 start positions.
module sme (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

`ifdef SME_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, OUT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] str_mem [0:31];
  logic [7:0] pat_mem [0:7];
  logic [5:0] str_len_reg;
  logic [3:0] pat_len_reg;
  logic [4:0] pos_reg;
  logic       found_reg;
  logic [4:0] found_idx_reg;
  logic       valid_reg, match_reg;
  logic [4:0] match_index_reg;

  // Load strobes: a "start" write goes to index 0, and a "cont" write appends.
  logic str_start, str_cont, pat_start, pat_cont;
  assign str_start = isstring && (state_reg == IDLE);
  assign str_cont  = isstring && (state_reg == LOAD_STR) && (str_len_reg != 6'd32);
  assign pat_start = ispattern && !isstring &&
                     ((state_reg == IDLE) || (state_reg == LOAD_STR));
  assign pat_cont  = ispattern && (state_reg == LOAD_PAT) && (pat_len_reg != 4'd8);

  // Pattern decode: the anchors wrap a core of ordinary elements and '.' elements.
  logic       has_caret, has_dollar;
  logic [7:0] last_char;
  logic [3:0] core_len;
  assign last_char  = pat_mem[3'(pat_len_reg - 4'd1)];
  assign has_caret  = (pat_len_reg != 4'd0) && (pat_mem[0] == 8'h5E);
  assign has_dollar = (pat_len_reg != 4'd0) && (last_char == 8'h24) &&
                      !((pat_len_reg == 4'd1) && has_caret);
  assign core_len   = pat_len_reg - {3'b0, has_caret} - {3'b0, has_dollar};

  // Test each core element against the string at the current start position.
  logic [5:0] pos_ext;
  logic [7:0] elem_ok;
  assign pos_ext = {1'b0, pos_reg};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_elem
      logic [5:0] spos;
      logic [7:0] pch, sch;
      assign spos = pos_ext + 6'(gi);
      assign pch  = pat_mem[3'({3'b0, has_caret} + 4'(gi))];
      assign sch  = str_mem[spos[4:0]];
      assign elem_ok[gi] = (4'(gi) >= core_len) ||
                           ((spos < str_len_reg) && ((pch == 8'h2E) || (pch == sch)));
    end
  endgenerate

  logic [5:0] end_pos;
  logic       caret_ok, dollar_ok, cand_ok;
  assign end_pos   = pos_ext + {2'b0, core_len};
  assign caret_ok  = !has_caret || (pos_reg == 5'd0) ||
                     (str_mem[pos_reg - 5'd1] == 8'h20);
  assign dollar_ok = !has_dollar || (end_pos == str_len_reg) ||
                     ((end_pos < str_len_reg) && (str_mem[end_pos[4:0]] == 8'h20));
  assign cand_ok   = (str_len_reg != 6'd0) && (pos_ext <= str_len_reg) &&
                     caret_ok && dollar_ok && (&elem_ok);

  // Result of the search, including the position being tested in this cycle.
  logic       hit_now;
  logic [4:0] idx_now;
  assign hit_now = found_reg || cand_ok;
  assign idx_now = found_reg ? found_idx_reg : pos_reg;

  // Next-state logic for the FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (isstring) state_next = LOAD_STR;
                else if (ispattern) state_next = LOAD_PAT;
      LOAD_STR: if (!isstring) state_next = ispattern ? LOAD_PAT : IDLE;
      LOAD_PAT: if (!ispattern) state_next = SEARCH;
      SEARCH:   if ((pos_reg == 5'd31) || (EarlyExit && cand_ok)) state_next = OUT;
      OUT:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Character storage. Contents do not need a reset because the lengths qualify them.
  always_ff @(posedge clk) begin
    if (str_start)     str_mem[0] <= chardata;
    else if (str_cont) str_mem[str_len_reg[4:0]] <= chardata;
    if (pat_start)     pat_mem[0] <= chardata;
    else if (pat_cont) pat_mem[pat_len_reg[2:0]] <= chardata;
  end

  // Lengths, the search cursor, and the registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_len_reg     <= 6'd0;
      pat_len_reg     <= 4'd0;
      pos_reg         <= 5'd0;
      found_reg       <= 1'b0;
      found_idx_reg   <= 5'd0;
      valid_reg       <= 1'b0;
      match_reg       <= 1'b0;
      match_index_reg <= 5'd0;
    end else begin
      if (str_start)     str_len_reg <= 6'd1;
      else if (str_cont) str_len_reg <= str_len_reg + 6'd1;
      if (pat_start)     pat_len_reg <= 4'd1;
      else if (pat_cont) pat_len_reg <= pat_len_reg + 4'd1;

      if (state_reg == LOAD_PAT) begin
        pos_reg   <= 5'd0;
        found_reg <= 1'b0;
      end else if (state_reg == SEARCH) begin
        pos_reg <= pos_reg + 5'd1;
        if (cand_ok && !found_reg) begin
          found_reg     <= 1'b1;
          found_idx_reg <= pos_reg;
        end
      end

      if ((state_reg == SEARCH) && (state_next == OUT)) begin
        valid_reg       <= 1'b1;
        match_reg       <= hit_now;
        match_index_reg <= hit_now ? idx_now : 5'd0;
      end else begin
        valid_reg       <= 1'b0;
        match_reg       <= 1'b0;
        match_index_reg <= 5'd0;
      end
    end
  end

  assign valid       = valid_reg;
  assign match       = match_reg;
  assign match_index = match_index_reg;

endmodule

// File: tb/tb_sme.sv
// tb_sme: directed testbench for sme. Each vector has expected values worked out by hand.
module tb_sme;
  logic       clk;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  int total = 0;
  int bad   = 0;

  sme dut (
    .clk(clk),
    .reset(reset),
    .chardata(chardata),
    .isstring(isstring),
    .ispattern(ispattern),
    .valid(valid),
    .match(match),
    .match_index(match_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      chardata = s[i];
      isstring = 1'b1;
      @(negedge clk);
    end
    isstring = 1'b0;
    chardata = 8'h00;
    repeat (2) @(negedge clk);
    $display("string loaded: \"%s\" (%0d chars)", s, s.len());
  endtask

  task automatic run_pat(input string p, input int exp_m, input int exp_i);
    int cyc;
    logic leak;
    for (int i = 0; i < p.len(); i++) begin
      chardata  = p[i];
      ispattern = 1'b1;
      @(negedge clk);
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    cyc  = 0;
    leak = 1'b0;
    while (!valid && cyc < 60) begin
      if (match || (match_index != 5'd0)) leak = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({p, " hold0"}, 32'(leak), 0);
    chk({p, " valid"}, 32'(valid), 1);
    chk({p, " latency"}, 32'(cyc <= 41), 1);
    chk({p, " match"}, 32'(match), 32'(exp_m));
    chk({p, " index"}, 32'(match_index), 32'(exp_i));
    $display("pattern \"%s\": match=%0d index=%0d cycles=%0d", p, match, match_index, cyc);
    @(negedge clk);
    chk({p, " pulse"}, 32'(valid), 0);
    @(negedge clk);
  endtask

  initial begin
    int vcount;
    reset     = 1'b0;
    chardata  = 8'h00;
    isstring  = 1'b0;
    ispattern = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(valid), 0);
    chk("rst match", 32'(match), 0);
    chk("rst index", 32'(match_index), 0);
    reset = 1'b1;
    @(negedge clk);

    load_str("hello world");
    run_pat("wor", 1, 6);
    run_pat(".l", 1, 1);
    run_pat("ld$", 1, 9);
    run_pat("^world$", 1, 6);
    run_pat("^ello", 0, 0);
    run_pat("xyz", 0, 0);

    load_str("a b");
    run_pat("^b$", 1, 2);
    run_pat("b ", 0, 0);

    load_str("abcdefghijklmnopqrstuvw012345xyz");
    run_pat("xyz", 1, 29);
    run_pat("12345xyz", 1, 24);
    run_pat("^abc", 1, 0);
    run_pat("abcdefgh99", 1, 0);

    // Apply reset in the middle of a pattern load.
    chardata  = "w";
    ispattern = 1'b1;
    @(negedge clk);
    chardata = "o";
    @(negedge clk);
    reset     = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    @(negedge clk);
    chk("midrst valid", 32'(valid), 0);
    chk("midrst match", 32'(match), 0);
    chk("midrst index", 32'(match_index), 0);
    reset = 1'b1;
    vcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    chk("midrst no valid", 32'(vcount), 0);
    $display("reset during pattern load: valid pulses afterwards=%0d", vcount);
    run_pat("a", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
